// File: rtl/button_input.sv
// Button input system register: sync + debounce of the active-low board button, sticky press
// flag and optional 6-bit press counter (BUTTON_INPUT_PRESS_COUNT_EN), read onto the 24-bit bus.
`timescale 1ns / 1ps

module button_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn,
  input  logic [1:0]  i_read,
  inout  wire  [23:0] io_bus,
  output logic        o_level,
  output logic        o_pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RdIdle  = 2'b00;
  localparam logic [1:0] RdClear = 2'b10;

  // Button polarity is kept raw (1 = released) up to the output.
  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_sticky;

  logic             w_accept;
  logic             w_press;
  logic             w_clear;
  logic [5:0]       w_count;
  logic [23:0]      w_rd_data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_accept = (r_sync2 != r_stable) && (r_db_cnt == CntMax);
  assign w_press  = w_accept && !r_sync2;
  assign w_clear  = (i_read == RdClear);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable <= 1'b1;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // A press on the same edge as a read-and-clear wins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sticky <= 1'b0;
    end else if (w_press) begin
      r_sticky <= 1'b1;
    end else if (w_clear) begin
      r_sticky <= 1'b0;
    end
  end

`ifdef BUTTON_INPUT_PRESS_COUNT_EN
  logic [5:0] r_press_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_press_cnt <= '0;
    end else if (w_press) begin
      r_press_cnt <= w_clear ? 6'd1 : r_press_cnt + 6'd1;
    end else if (w_clear) begin
      r_press_cnt <= '0;
    end
  end

  assign w_count = r_press_cnt;
`else
  assign w_count = '0;
`endif

  assign o_level   = ~r_stable;
  assign o_pressed = r_sticky;

  assign w_rd_data = {16'h0000, w_count, r_sticky, ~r_stable};
  assign io_bus    = (i_read != RdIdle) ? w_rd_data : 24'bz;

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with DEBOUNCE_CYCLES = 4; expected counter field follows
// BUTTON_INPUT_PRESS_COUNT_EN.
`timescale 1ns / 1ps

module tb_button_input;

  logic        clk;
  logic        rst_n;
  logic        btn;
  logic [1:0]  rd;
  wire  [23:0] bus;
  logic        level;
  logic        pressed;

  int n_cmp = 0;
  int n_err = 0;

  // Undriven bus bits read as 1 through the pull-ups.
  for (genvar g = 0; g < 24; g++) begin : g_pu
    pullup (bus[g]);
  end

  button_input #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_btn    (btn),
    .i_read   (rd),
    .io_bus   (bus),
    .o_level  (level),
    .o_pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [23:0] rd_word(input int cnt, input logic stk, input logic lvl);
    logic [5:0] c;
`ifdef BUTTON_INPUT_PRESS_COUNT_EN
    c = 6'(cnt);
`else
    c = 6'd0;
`endif
    return {16'h0000, c, stk, lvl};
  endfunction

  task automatic read_check(input string tag, input logic [1:0] mode, input logic [23:0] exp);
    rd = mode;
    #1;
    check_eq(tag, bus, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b1;
    rd    = 2'b00;
    #12;
    check_eq("rst_level", {23'd0, level}, 24'd0);
    check_eq("rst_pressed", {23'd0, pressed}, 24'd0);
    check_eq("rst_bus_z", bus, 24'hFFFFFF);
    read_check("rst_read", 2'b01, 24'h000000);
    rd = 2'b00;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Plain press: o_level rises on the 6th edge after the first sampling edge.
    btn = 1'b0;
    tick(5);
    check_eq("lat_level_e5", {23'd0, level}, 24'd0);
    check_eq("lat_pressed_e5", {23'd0, pressed}, 24'd0);
    tick(1);
    check_eq("lat_level_e6", {23'd0, level}, 24'd1);
    check_eq("lat_pressed_e6", {23'd0, pressed}, 24'd1);
    read_check("press_read", 2'b01, rd_word(1, 1'b1, 1'b1));
    rd = 2'b00;
    #1;
    check_eq("idle_bus_z", bus, 24'hFFFFFF);

    btn = 1'b1;
    tick(5);
    check_eq("rel_level_e5", {23'd0, level}, 24'd1);
    tick(1);
    check_eq("rel_level_e6", {23'd0, level}, 24'd0);
    check_eq("rel_pressed", {23'd0, pressed}, 24'd1);

    // Glitch restart: 3 low, 1 high, then a held low run.
    btn = 1'b0;
    tick(3);
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(5);
    check_eq("glitch_level_pre", {23'd0, level}, 24'd0);
    tick(1);
    check_eq("glitch_level_acc", {23'd0, level}, 24'd1);
    btn = 1'b1;
    tick(6);
    check_eq("glitch_rel_level", {23'd0, level}, 24'd0);

    // Read-and-clear after two presses.
    read_check("rdclr_data", 2'b10, rd_word(2, 1'b1, 1'b0));
    tick(1);
    rd = 2'b00;
    check_eq("rdclr_pressed", {23'd0, pressed}, 24'd0);
    read_check("rdclr_after", 2'b01, rd_word(0, 1'b0, 1'b0));
    rd = 2'b00;

    // Read-and-clear on the same edge as a press event: set wins.
    btn = 1'b0;
    tick(5);
    read_check("coinc_pre", 2'b10, rd_word(0, 1'b0, 1'b0));
    tick(1);
    rd = 2'b00;
    check_eq("coinc_pressed", {23'd0, pressed}, 24'd1);
    check_eq("coinc_level", {23'd0, level}, 24'd1);
    read_check("coinc_read", 2'b01, rd_word(1, 1'b1, 1'b1));

    // Held read-and-clear clears on every edge.
    rd = 2'b10;
    tick(1);
    #1;
    check_eq("hold_clr_1", bus, rd_word(0, 1'b0, 1'b1));
    tick(1);
    check_eq("hold_clr_2", bus, rd_word(0, 1'b0, 1'b1));
    rd = 2'b00;
    btn = 1'b1;
    tick(6);
    check_eq("hold_rel_level", {23'd0, level}, 24'd0);

    // Reset mid-debounce (counter = 2) with the button held low.
    btn = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_level", {23'd0, level}, 24'd0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check_eq("post_rst_e5", {23'd0, level}, 24'd0);
    tick(1);
    check_eq("post_rst_e6", {23'd0, level}, 24'd1);
    read_check("post_rst_read", 2'b01, rd_word(1, 1'b1, 1'b1));
    rd = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
